// File: rtl/uart_rx_core_if.sv
// Bundle of the serial receiver's line input and its byte/status outputs.
// The core takes the master modport. A consumer or test driver takes the slave modport.
interface uart_rx_core_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       frame_error;
  logic       busy;

  modport master (
    input  rx,
    output rx_data,
    output rx_ready,
    output frame_error,
    output busy
  );

  modport slave (
    output rx,
    input  rx_data,
    input  rx_ready,
    input  frame_error,
    input  busy
  );
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with 16x oversampling and mid-bit sampling.
// Emits a one-cycle pulse per frame: rx_ready for a good stop bit, frame_error for a bad one.
module uart_rx_core #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic           clk,
  input  logic           reset,
  uart_rx_core_if.master bus
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic             r_rx_meta;
  logic             r_rx_sync;
  logic             r_rx_prev;
  logic [DIV_W-1:0] r_div_cnt;
  logic [3:0]       r_tick_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic [7:0]       r_rx_data;
  logic             r_rx_ready;
  logic             r_frame_error;

  logic w_tick;
  logic w_fall;
  logic w_mid_tick;
  logic w_last_tick;
  logic w_busy;
  logic w_cnt_clr;
  logic w_bit_sample;
  logic w_stop_ok;
  logic w_stop_bad;

  // Two synchronizer flops, then one more flop for falling-edge detection.
  // All three reset to 1 because the idle line is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= bus.rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  assign w_fall      = r_rx_prev & ~r_rx_sync;
  assign w_tick      = (r_div_cnt == DIV_W'(DIV - 1));
  assign w_mid_tick  = w_tick && (r_tick_cnt == 4'd7);
  assign w_last_tick = w_tick && (r_tick_cnt == 4'd15);

  // Oversampling divider. It is held at zero while idle.
  // Because of that, the first tick after a start edge is phase-aligned to the edge.
  always_ff @(posedge clk) begin
    if (reset || w_cnt_clr) begin
      r_div_cnt <= '0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || w_cnt_clr) begin
      r_tick_cnt <= 4'd0;
    end else if (w_tick) begin
      r_tick_cnt <= r_tick_cnt + 4'd1;
    end
  end

  // FSM: state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_fall) begin
          w_state_next = ST_START;
        end
      end
      ST_START: begin
        if (w_mid_tick) begin
          w_state_next = r_rx_sync ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_last_tick && (r_bit_cnt == 3'd7)) begin
          w_state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_last_tick) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // FSM: output/strobe logic.
  always_comb begin
    w_busy       = 1'b1;
    w_cnt_clr    = 1'b0;
    w_bit_sample = 1'b0;
    w_stop_ok    = 1'b0;
    w_stop_bad   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy    = 1'b0;
        w_cnt_clr = 1'b1;
      end
      ST_START: begin
        w_cnt_clr = w_mid_tick && !r_rx_sync;
      end
      ST_DATA: begin
        w_bit_sample = w_last_tick;
      end
      ST_STOP: begin
        w_stop_ok  = w_last_tick && r_rx_sync;
        w_stop_bad = w_last_tick && !r_rx_sync;
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  // Shift right so the first-received bit lands in bit 0.
  // The 3-bit bit counter wraps back to 0 after the eighth data bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift   <= 8'h00;
      r_bit_cnt <= 3'd0;
    end else if (w_bit_sample) begin
      r_shift   <= {r_rx_sync, r_shift[7:1]};
      r_bit_cnt <= r_bit_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_data     <= 8'h00;
      r_rx_ready    <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_rx_ready    <= w_stop_ok;
      r_frame_error <= w_stop_bad;
      if (w_stop_ok) begin
        r_rx_data <= r_shift;
      end
    end
  end

  assign bus.rx_data     = r_rx_data;
  assign bus.rx_ready    = r_rx_ready;
  assign bus.frame_error = r_frame_error;
  assign bus.busy        = w_busy;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core with DIV=1, so one bit lasts 16 clk cycles.
// Expected bytes and pulse counts are written by hand for each scenario.
module tb_uart_rx_core;

  localparam int BIT_CLKS = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  uart_rx_core_if uif();

  uart_rx_core #(
    .CLK_FREQ (1_600_000),
    .BAUD_RATE(100_000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (uif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int         ready_cnt     = 0;
  int         fe_cnt        = 0;
  int         both_cnt      = 0;
  int         long_cnt      = 0;
  int         busy_run      = 0;
  int         last_busy_run = 0;
  logic       prev_ready    = 1'b0;
  logic [7:0] data_q[$];

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    prev_ready <= uif.rx_ready;
    if (uif.rx_ready) begin
      ready_cnt <= ready_cnt + 1;
      data_q.push_back(uif.rx_data);
    end
    if (uif.frame_error) fe_cnt <= fe_cnt + 1;
    if (uif.rx_ready && uif.frame_error) both_cnt <= both_cnt + 1;
    if (uif.rx_ready && prev_ready) long_cnt <= long_cnt + 1;
    if (uif.busy) begin
      busy_run <= busy_run + 1;
    end else begin
      if (busy_run != 0) last_busy_run <= busy_run;
      busy_run <= 0;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends one 8N1 frame.
  // When rst_bit matches a data-bit index, reset is pulsed for one clk in the middle of that bit.
  task automatic send_byte(input logic [7:0] b, input logic stop_val, input int rst_bit);
    uif.rx = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      uif.rx = b[i];
      if (i == rst_bit) begin
        wait_clks(BIT_CLKS / 2);
        reset = 1'b1;
        wait_clks(1);
        reset = 1'b0;
        wait_clks(BIT_CLKS / 2 - 1);
      end else begin
        wait_clks(BIT_CLKS);
      end
    end
    uif.rx = stop_val;
    wait_clks(BIT_CLKS);
    uif.rx = 1'b1;
  endtask

  task automatic test_reset();
    uif.rx = 1'b1;
    reset  = 1'b1;
    wait_clks(4);
    n_checks++;
    if (uif.rx_data !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_rx_data: got %h expected 00", uif.rx_data);
    end
    n_checks++;
    if (uif.rx_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_rx_ready: got %b expected 0", uif.rx_ready);
    end
    n_checks++;
    if (uif.frame_error !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_frame_error: got %b expected 0", uif.frame_error);
    end
    n_checks++;
    if (uif.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_busy: got %b expected 0", uif.busy);
    end
    reset = 1'b0;
    wait_clks(4);
    $display("test_reset done");
  endtask

  task automatic test_valid_frame();
    int r0 = ready_cnt;
    int f0 = fe_cnt;
    send_byte(8'hA5, 1'b1, -1);
    wait_clks(20);
    n_checks++;
    if (ready_cnt - r0 !== 1) begin
      n_errors++;
      $display("FAIL a5_ready_count: got %0d expected 1", ready_cnt - r0);
    end
    n_checks++;
    if (uif.rx_data !== 8'hA5) begin
      n_errors++;
      $display("FAIL a5_rx_data: got %h expected a5", uif.rx_data);
    end
    n_checks++;
    if (fe_cnt - f0 !== 0) begin
      n_errors++;
      $display("FAIL a5_frame_error_count: got %0d expected 0", fe_cnt - f0);
    end
    n_checks++;
    if (uif.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL a5_busy_idle: got %b expected 0", uif.busy);
    end
    $display("test_valid_frame: sent a5, rx_data=%h", uif.rx_data);
  endtask

  task automatic test_glitch();
    int r0 = ready_cnt;
    int f0 = fe_cnt;
    uif.rx = 1'b0;
    wait_clks(4);
    uif.rx = 1'b1;
    wait_clks(40);
    n_checks++;
    if (ready_cnt - r0 !== 0) begin
      n_errors++;
      $display("FAIL glitch_ready_count: got %0d expected 0", ready_cnt - r0);
    end
    n_checks++;
    if (fe_cnt - f0 !== 0) begin
      n_errors++;
      $display("FAIL glitch_frame_error_count: got %0d expected 0", fe_cnt - f0);
    end
    n_checks++;
    if (uif.rx_data !== 8'hA5) begin
      n_errors++;
      $display("FAIL glitch_rx_data: got %h expected a5", uif.rx_data);
    end
    n_checks++;
    if ((last_busy_run > 0 && last_busy_run < 10) !== 1'b1) begin
      n_errors++;
      $display("FAIL glitch_busy_len: got %0d expected 1..9", last_busy_run);
    end
    $display("test_glitch: busy run %0d clks", last_busy_run);
  endtask

  task automatic test_frame_error();
    int r0 = ready_cnt;
    int f0 = fe_cnt;
    send_byte(8'h3C, 1'b0, -1);
    wait_clks(20);
    n_checks++;
    if (fe_cnt - f0 !== 1) begin
      n_errors++;
      $display("FAIL ferr_count: got %0d expected 1", fe_cnt - f0);
    end
    n_checks++;
    if (ready_cnt - r0 !== 0) begin
      n_errors++;
      $display("FAIL ferr_ready_count: got %0d expected 0", ready_cnt - r0);
    end
    n_checks++;
    if (uif.rx_data !== 8'hA5) begin
      n_errors++;
      $display("FAIL ferr_rx_data: got %h expected a5", uif.rx_data);
    end
    $display("test_frame_error: sent 3c with low stop, rx_data=%h", uif.rx_data);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_bytes[5] = '{8'h34, 8'h12, 8'h78, 8'h56, 8'h02};
    int r0 = ready_cnt;
    int f0 = fe_cnt;
    int q0 = data_q.size();
    for (int i = 0; i < 5; i++) begin
      send_byte(exp_bytes[i], 1'b1, -1);
    end
    wait_clks(20);
    n_checks++;
    if (ready_cnt - r0 !== 5) begin
      n_errors++;
      $display("FAIL b2b_ready_count: got %0d expected 5", ready_cnt - r0);
    end
    n_checks++;
    if (fe_cnt - f0 !== 0) begin
      n_errors++;
      $display("FAIL b2b_frame_error_count: got %0d expected 0", fe_cnt - f0);
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (q0 + i >= data_q.size()) begin
        n_errors++;
        $display("FAIL b2b_byte%0d: got none expected %h", i, exp_bytes[i]);
      end else if (data_q[q0 + i] !== exp_bytes[i]) begin
        n_errors++;
        $display("FAIL b2b_byte%0d: got %h expected %h", i, data_q[q0 + i], exp_bytes[i]);
      end else begin
        $display("test_back_to_back: byte %0d = %h", i, data_q[q0 + i]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int r0 = ready_cnt;
    int f0 = fe_cnt;
    send_byte(8'hFF, 1'b1, 3);
    wait_clks(20);
    n_checks++;
    if (ready_cnt - r0 !== 0) begin
      n_errors++;
      $display("FAIL rstmid_ready_count: got %0d expected 0", ready_cnt - r0);
    end
    n_checks++;
    if (fe_cnt - f0 !== 0) begin
      n_errors++;
      $display("FAIL rstmid_frame_error_count: got %0d expected 0", fe_cnt - f0);
    end
    n_checks++;
    if (uif.rx_data !== 8'h00) begin
      n_errors++;
      $display("FAIL rstmid_rx_data: got %h expected 00", uif.rx_data);
    end
    n_checks++;
    if (uif.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL rstmid_busy: got %b expected 0", uif.busy);
    end
    r0 = ready_cnt;
    send_byte(8'h5A, 1'b1, -1);
    wait_clks(20);
    n_checks++;
    if (ready_cnt - r0 !== 1) begin
      n_errors++;
      $display("FAIL post_rst_ready_count: got %0d expected 1", ready_cnt - r0);
    end
    n_checks++;
    if (uif.rx_data !== 8'h5A) begin
      n_errors++;
      $display("FAIL post_rst_rx_data: got %h expected 5a", uif.rx_data);
    end
    $display("test_reset_midframe: after reset, 5a received as %h", uif.rx_data);
  endtask

  task automatic test_pulse_rules();
    n_checks++;
    if (both_cnt !== 0) begin
      n_errors++;
      $display("FAIL ready_and_ferr_overlap: got %0d cycles expected 0", both_cnt);
    end
    n_checks++;
    if (long_cnt !== 0) begin
      n_errors++;
      $display("FAIL ready_pulse_width: got %0d extended cycles expected 0", long_cnt);
    end
    $display("test_pulse_rules: overlap=%0d extended=%0d", both_cnt, long_cnt);
  endtask

  initial begin
    uif.rx = 1'b1;
    test_reset();
    test_valid_frame();
    test_glitch();
    test_frame_error();
    test_back_to_back();
    test_reset_midframe();
    test_pulse_rules();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
